// File: rtl/sha1_pkg.sv
// sha1_pkg: shared constants and types for the SHA-1 compression core.
//   WORD_W / NUM_ROUNDS  - word width and rounds per 512-bit block
//   H_INIT               - initial chaining values H0..H4
//   K_0..K_3             - round constants, one per 20-round stage
//   state_t              - block-processing FSM states
//   rotl()               - 32-bit rotate-left helper
package sha1_pkg;

  localparam int WORD_W     = 32;
  localparam int NUM_ROUNDS = 80;
  localparam int STAGE_LEN  = 20;

  localparam logic [31:0] H_INIT [0:4] = '{
    32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
  };

  localparam logic [31:0] K_0 = 32'h5A827999;
  localparam logic [31:0] K_1 = 32'h6ED9EBA1;
  localparam logic [31:0] K_2 = 32'h8F1BBCDC;
  localparam logic [31:0] K_3 = 32'hCA62C1D6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } state_t;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sha1_if.sv
// sha1_if: bundles the block-input handshake, the schedule-stage link and
// the digest output of sha1_core.
//   slave  modport - the core's view
//   master modport - the environment's view (padder, schedule stage, sink)
interface sha1_if;
  import sha1_pkg::*;

  logic               blk_valid;
  logic               blk_ready;
  logic [511:0]       blk_data;
  logic               blk_first;
  logic               blk_last;
  logic [7:0]         t;
  logic               valid_w;
  logic [511:0]       din;
  logic [WORD_W-1:0]  w;
  logic [159:0]       digest;
  logic               digest_valid;

  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last, w,
    output blk_ready, t, valid_w, din, digest, digest_valid
  );

  modport master (
    output blk_valid, blk_data, blk_first, blk_last, w,
    input  blk_ready, t, valid_w, din, digest, digest_valid
  );

endinterface

// File: rtl/sha1_f.sv
// sha1_f: combinational round function and round constant selection.
//   i_t         - round index 0..79
//   i_b/i_c/i_d - working variables b, c, d
//   o_f         - Ch / Parity / Maj / Parity of b,c,d for the round's stage
//   o_k         - matching round constant
module sha1_f
  import sha1_pkg::*;
(
  input  logic [7:0]  i_t,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_f,
  output logic [31:0] o_k
);

  always_comb begin
    o_f = i_b ^ i_c ^ i_d;
    o_k = K_3;
    if (i_t < 8'(STAGE_LEN)) begin
      o_f = (i_b & i_c) | (~i_b & i_d);
      o_k = K_0;
    end else if (i_t < 8'(2 * STAGE_LEN)) begin
      o_f = i_b ^ i_c ^ i_d;
      o_k = K_1;
    end else if (i_t < 8'(3 * STAGE_LEN)) begin
      o_f = (i_b & i_c) | (i_b & i_d) | (i_c & i_d);
      o_k = K_2;
    end
  end

endmodule

// File: rtl/sha1_core.sv
// sha1_core: iterative SHA-1 compression, one round per cycle.
//   clk, rst        - clock, asynchronous active-high reset
//   bus (slave)     - blk_valid/blk_ready/blk_data/blk_first/blk_last from
//                     the padder; t/valid_w/din to the schedule stage and w
//                     back from it; digest/digest_valid to the consumer.
// A block takes 83 cycles: IDLE (handshake), LOAD, 80 x ROUND, FINAL.
module sha1_core
  import sha1_pkg::*;
#(
  parameter int N      = WORD_W,
  parameter int ROUNDS = NUM_ROUNDS
) (
  input  logic  clk,
  input  logic  rst,
  sha1_if.slave bus
);

  state_t         r_state;
  state_t         w_state_next;
  logic [7:0]     r_t;
  logic [511:0]   r_din;
  logic           r_last;
  logic           r_pub_pending;
  logic [N-1:0]   r_a, r_b, r_c, r_d, r_e;
  logic [N-1:0]   r_h [0:4];
  logic [159:0]   r_digest;
  logic           r_digest_valid;

  logic           w_blk_ready;
  logic           w_valid_w;
  logic           w_accept;
  logic           w_last_round;
  logic [N-1:0]   w_f, w_k, w_temp;
  logic [159:0]   w_h_cat;

  assign w_last_round = (r_t == 8'(ROUNDS - 1));

  for (genvar gi = 0; gi < 5; gi++) begin : g_hcat
    assign w_h_cat[159 - 32*gi -: 32] = r_h[gi];
  end

  sha1_f u_f (
    .i_t (r_t),
    .i_b (r_b),
    .i_c (r_c),
    .i_d (r_d),
    .o_f (w_f),
    .o_k (w_k)
  );

  // w is the schedule word for the current t, valid in the same cycle
  assign w_temp = rotl(r_a, 5) + w_f + r_e + w_k + bus.w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_blk_ready  = 1'b0;
    w_valid_w    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_blk_ready = 1'b1;
        if (bus.blk_valid) begin
          w_accept     = 1'b1;
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_valid_w    = 1'b1;
        w_state_next = ROUND;
      end
      ROUND: begin
        if (w_last_round) w_state_next = FINAL;
      end
      FINAL: begin
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t            <= '0;
      r_din          <= '0;
      r_last         <= 1'b0;
      r_pub_pending  <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_c            <= '0;
      r_d            <= '0;
      r_e            <= '0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      for (int i = 0; i < 5; i++) r_h[i] <= H_INIT[i];
    end else begin
      r_digest_valid <= 1'b0;
      // Publish one cycle after FINAL so the digest sees the summed H; a
      // blk_first accepted in that same cycle still reads the old H here.
      if (r_pub_pending) begin
        r_digest       <= w_h_cat;
        r_digest_valid <= 1'b1;
        r_pub_pending  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_din  <= bus.blk_data;
            r_last <= bus.blk_last;
            if (bus.blk_first) begin
              for (int i = 0; i < 5; i++) r_h[i] <= H_INIT[i];
            end
          end
        end
        LOAD: begin
          // H was already reinitialised at the handshake for a first block
          r_a <= r_h[0];
          r_b <= r_h[1];
          r_c <= r_h[2];
          r_d <= r_h[3];
          r_e <= r_h[4];
          r_t <= '0;
        end
        ROUND: begin
          r_e <= r_d;
          r_d <= r_c;
          r_c <= rotl(r_b, 30);
          r_b <= r_a;
          r_a <= w_temp;
          r_t <= w_last_round ? 8'd0 : r_t + 8'd1;
        end
        FINAL: begin
          r_h[0] <= r_h[0] + r_a;
          r_h[1] <= r_h[1] + r_b;
          r_h[2] <= r_h[2] + r_c;
          r_h[3] <= r_h[3] + r_d;
          r_h[4] <= r_h[4] + r_e;
          if (r_last) r_pub_pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.blk_ready    = w_blk_ready;
  assign bus.valid_w      = w_valid_w;
  assign bus.t            = r_t;
  assign bus.din          = r_din;
  assign bus.digest       = r_digest;
  assign bus.digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha1_core.sv
module tb_sha1_core;
  import sha1_pkg::*;

  logic clk = 1'b0;
  logic rst;

  sha1_if bus();

  sha1_core #(.N(32), .ROUNDS(80)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [159:0] H0_INIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_EMP = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [511:0] din_snap = '0;
  logic [159:0] model_h;
  logic [159:0] dv_q[$];
  int           dvc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sched_word(input logic [511:0] blk, input int t);
    logic [31:0] ws [0:79];
    for (int i = 0; i < 80; i++) begin
      if (i < 16) ws[i] = blk[511 - 32*i -: 32];
      else        ws[i] = rol(ws[i-3] ^ ws[i-8] ^ ws[i-14] ^ ws[i-16], 1);
    end
    if (t < 0 || t > 79) return 32'h0;
    return ws[t];
  endfunction

  function automatic logic [159:0] sha1_compress(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] a, b, c, d, e, f, k, tmp;
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rol(a, 5) + f + e + k + sched_word(blk, i);
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  task automatic pad_msg(input byte unsigned msg[$], output logic [511:0] blks[$]);
    byte unsigned bq[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    bq = msg;
    bitlen = 64'(msg.size()) * 64'd8;
    bq.push_back(8'h80);
    while (bq.size() % 64 != 56) bq.push_back(8'h00);
    for (int i = 7; i >= 0; i--) bq.push_back(bitlen[8*i +: 8]);
    blks.delete();
    for (int kk = 0; kk < bq.size() / 64; kk++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = bq[64*kk + j];
      blks.push_back(blk);
    end
  endtask

  task automatic str_bytes(input string s, output byte unsigned q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(byte'(s[i]));
  endtask

  // schedule stage stand-in: captures din on valid_w, serves W[t] combinationally
  always @(negedge clk) if (bus.valid_w === 1'b1) din_snap <= bus.din;
  assign bus.w = sched_word(din_snap, int'(bus.t));

  always @(negedge clk) begin
    if (bus.digest_valid === 1'b1) begin
      dv_q.push_back(bus.digest);
      dvc_q.push_back(cyc);
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic send_block(input logic [511:0] blk, input bit first, input bit last,
                            input bit hold, output int hs_cyc, output int rdy_cyc, output bit ok);
    @(negedge clk);
    bus.blk_data  = blk;
    bus.blk_first = first;
    bus.blk_last  = last;
    bus.blk_valid = 1'b1;
    ok = 1'b0;
    rdy_cyc = -1;
    hs_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.blk_ready === 1'b1) begin
        rdy_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check_eq("handshake_timeout", 512'd0, 512'd1);
      bus.blk_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    check_eq("din_capture", bus.din, blk);
    if (!hold) bus.blk_valid = 1'b0;
  endtask

  task automatic wait_digest(output logic [159:0] d, output int c, output bit ok);
    ok = 1'b0;
    d = '0;
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (dv_q.size() > 0) begin
        d = dv_q.pop_front();
        c = dvc_q.pop_front();
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("digest_timeout", 512'd0, 512'd1);
  endtask

  task automatic run_msg(input byte unsigned msg[$], input string tag, input bit first_on,
                         input bit use_known, input logic [159:0] known);
    logic [511:0] blks[$];
    logic [159:0] h, d;
    int hs, rdy, c;
    bit ok;
    pad_msg(msg, blks);
    h = first_on ? H0_INIT : model_h;
    foreach (blks[kk]) h = sha1_compress(h, blks[kk]);
    for (int kk = 0; kk < blks.size(); kk++) begin
      send_block(blks[kk], first_on && (kk == 0), kk == blks.size() - 1, 1'b0, hs, rdy, ok);
      if (!ok) return;
    end
    wait_digest(d, c, ok);
    if (!ok) return;
    check_eq({tag, "_digest"}, 512'(d), 512'(use_known ? known : h));
    check_eq({tag, "_latency"}, 512'(c - hs), 512'd83);
    repeat (4) @(posedge clk);
    check_eq({tag, "_single_pulse"}, 512'(dv_q.size()), 512'd0);
    model_h = h;
    $display("[TB] msg %s bytes=%0d blocks=%0d first=%0d digest=%h", tag, msg.size(), blks.size(), first_on, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_blk_ready"}, 512'(bus.blk_ready), 512'd1);
    check_eq({tag, "_t"}, 512'(bus.t), 512'd0);
    check_eq({tag, "_valid_w"}, 512'(bus.valid_w), 512'd0);
    check_eq({tag, "_din"}, bus.din, 512'd0);
    check_eq({tag, "_digest"}, 512'(bus.digest), 512'd0);
    check_eq({tag, "_digest_valid"}, 512'(bus.digest_valid), 512'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte unsigned m_abc[$], m_emp[$], m_two[$], m_rnd[$];
    logic [511:0] b_abc[$], b_emp[$], b_tog;
    logic [159:0] d1, d2;
    int hs1, hs2, rdy, rdy3, c1, c2, bad_t, extra_vw, rdy_hi, len;
    bit ok, ok2, found;

    rst           = 1'b1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.blk_first = 1'b0;
    bus.blk_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_h = H0_INIT;

    str_bytes("abc", m_abc);
    m_emp.delete();
    str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", m_two);

    run_msg(m_abc, "abc", 1'b1, 1'b1, DIG_ABC);
    run_msg(m_emp, "empty", 1'b1, 1'b1, DIG_EMP);
    run_msg(m_two, "two_block", 1'b1, 1'b1, DIG_TWO);

    // back-to-back with blk_valid held high
    pad_msg(m_abc, b_abc);
    pad_msg(m_emp, b_emp);
    send_block(b_abc[0], 1'b1, 1'b1, 1'b1, hs1, rdy, ok);
    send_block(b_emp[0], 1'b1, 1'b1, 1'b1, hs2, rdy, ok2);
    bus.blk_valid = 1'b0;
    if (ok && ok2) begin
      check_eq("b2b_ready1", 512'(rdy - hs1), 512'd82);
      rdy3 = -1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (bus.blk_ready === 1'b1) begin rdy3 = cyc; break; end
      end
      check_eq("b2b_ready2", 512'(rdy3 - hs2), 512'd82);
      wait_digest(d1, c1, ok);
      wait_digest(d2, c2, ok2);
      check_eq("b2b_digest1", 512'(d1), 512'(DIG_ABC));
      check_eq("b2b_lat1", 512'(c1 - hs1), 512'd83);
      check_eq("b2b_digest2", 512'(d2), 512'(DIG_EMP));
      check_eq("b2b_lat2", 512'(c2 - hs2), 512'd83);
      model_h = DIG_EMP;
      $display("[TB] msg back_to_back digest1=%h digest2=%h", d1, d2);
    end

    // blk_valid toggling while the core is busy
    b_tog = b_abc[0];
    send_block(b_tog, 1'b1, 1'b1, 1'b0, hs1, rdy, ok);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.valid_w === 1'b1) begin found = 1'b1; break; end
    end
    check_eq("tog_valid_w_seen", 512'(found), 512'd1);
    bad_t = 0; extra_vw = 0; rdy_hi = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.t !== 8'(i)) bad_t++;
      if (bus.valid_w === 1'b1) extra_vw++;
      if (bus.blk_ready === 1'b1) rdy_hi++;
      bus.blk_valid = 1'($urandom_range(0, 1));
      bus.blk_first = 1'($urandom_range(0, 1));
      bus.blk_data  = {16{$urandom}};
    end
    bus.blk_valid = 1'b0;
    bus.blk_first = 1'b0;
    check_eq("tog_t_sequence_errors", 512'(bad_t), 512'd0);
    check_eq("tog_extra_valid_w", 512'(extra_vw), 512'd0);
    check_eq("tog_ready_while_busy", 512'(rdy_hi), 512'd0);
    @(negedge clk);
    check_eq("tog_t_final", 512'(bus.t), 512'd0);
    check_eq("tog_din_held", bus.din, b_tog);
    wait_digest(d1, c1, ok);
    check_eq("tog_digest", 512'(d1), 512'(DIG_ABC));
    check_eq("tog_latency", 512'(c1 - hs1), 512'd83);
    repeat (4) @(posedge clk);
    check_eq("tog_single_pulse", 512'(dv_q.size()), 512'd0);
    model_h = DIG_ABC;
    $display("[TB] msg toggle_valid digest=%h", d1);

    // asynchronous reset in the middle of a block
    send_block(b_abc[0], 1'b1, 1'b1, 1'b0, hs1, rdy, ok);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.t === 8'd40) begin found = 1'b1; break; end
    end
    check_eq("rst_reached_t40", 512'(found), 512'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_h = H0_INIT;
    repeat (100) @(posedge clk);
    check_eq("midrst_no_digest", 512'(dv_q.size()), 512'd0);
    $display("[TB] msg mid_round_reset aborted");
    // a block without blk_first must chain from the reset H value
    run_msg(m_emp, "chain_after_rst", 1'b0, 1'b1, DIG_EMP);
    run_msg(m_abc, "abc_after_rst", 1'b1, 1'b1, DIG_ABC);

    // randomized messages against the model, some chained onto the current H
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, 130);
      m_rnd.delete();
      for (int i = 0; i < len; i++) m_rnd.push_back(8'($urandom_range(0, 255)));
      run_msg(m_rnd, "rand", $urandom_range(0, 3) != 0, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
